// File: rtl/raster_stamp_fetch_pkg.sv
// raster_stamp_fetch_pkg
// Shared types and constants for the raster stamp fetch block.
//   raster_stamp_t : one stamp as produced by the rasterizer
//   raster_csrs_t  : per-lane CSR state (pos_mask word + 12 bcoords words)
//   fetchState_e   : states of the fetch controller
// Also holds the pos_mask field layout, the result-word valid bit and
// the CSR index map shared by the controller, the CSR file and the core.
package raster_stamp_fetch_pkg;

    localparam int VX_RASTER_DIM_BITS = 12;
    localparam int PID_BITS           = 16;

    // pos_mask word layout: mask in the low nibble, then pos_x, then pos_y
    localparam int POS_MASK_MASK_LSB = 0;
    localparam int POS_MASK_MASK_W   = 4;
    localparam int POS_W             = VX_RASTER_DIM_BITS - 1;
    localparam int POS_X_LSB         = POS_MASK_MASK_W;
    localparam int POS_Y_LSB         = POS_X_LSB + POS_W;

    // The packed position word must fit in one 32-bit CSR; the top module
    // turns a violation into an elaboration error
    localparam bit POS_MASK_FITS = (2 * POS_W + POS_MASK_MASK_W) <= 32;

    // Result word: bit 31 flags "this lane received a stamp"
    localparam int RSP_VALID_BIT = 31;

    // CSR index map as seen by the core's CSR unit
    localparam int RASTER_CSR_POS_MASK = 0;
    localparam int RASTER_CSR_BCOORD0  = 1;
    localparam int RASTER_CSR_COUNT    = 13;

    typedef struct packed {
        logic [POS_W-1:0]       pos_x;
        logic [POS_W-1:0]       pos_y;
        logic [3:0]             mask;
        logic [2:0][3:0][31:0]  bcoords;
        logic [PID_BITS-1:0]    pid;
    } raster_stamp_t;

    typedef struct packed {
        logic [31:0]            pos_mask;
        logic [2:0][3:0][31:0]  bcoords;
    } raster_csrs_t;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_COLLECT,
        FETCH_RESPOND
    } fetchState_e;

    // Builds the pos_mask CSR word from a stamp; unused upper bits stay 0
    function automatic logic [31:0] packPosMask(input raster_stamp_t s);
        logic [31:0] w;
        w = '0;
        w[POS_MASK_MASK_LSB +: POS_MASK_MASK_W] = s.mask;
        w[POS_X_LSB +: POS_W]                   = s.pos_x;
        w[POS_Y_LSB +: POS_W]                   = s.pos_y;
        return w;
    endfunction

endpackage

// File: rtl/raster_stamp_fetch_csr_file.sv
// raster_csr_file
// Per-warp/per-lane storage of the raster CSR state.
//   clk, reset            : clock, synchronous active-high reset
//   wr_en_i/wid/lane/data : full-entry write (pos_mask + bcoords)
//   clr_en_i/wid/lanes    : clears pos_mask of the selected lanes of one warp
//   rd_en_i/wid/lane/idx  : indexed 32-bit read strobe
//   rd_data_o             : registered read data, held until the next strobe
module raster_csr_file
    import raster_stamp_fetch_pkg::*;
#(
    parameter int NUM_WARPS = 4,
    parameter int NUM_LANES = 4,
    parameter int WB        = 2,
    parameter int LB        = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [WB-1:0]         wr_wid_i,
    input  logic [LB-1:0]         wr_lane_i,
    input  raster_csrs_t          wr_data_i,
    input  logic                  clr_en_i,
    input  logic [WB-1:0]         clr_wid_i,
    input  logic [NUM_LANES-1:0]  clr_lanes_i,
    input  logic                  rd_en_i,
    input  logic [WB-1:0]         rd_wid_i,
    input  logic [LB-1:0]         rd_lane_i,
    input  logic [3:0]            rd_idx_i,
    output logic [31:0]           rd_data_o
);

    logic [31:0]           posMask_q [NUM_WARPS][NUM_LANES];
    logic [2:0][3:0][31:0] bcoords_q [NUM_WARPS][NUM_LANES];
    logic [31:0]           rdData_q;
    logic [3:0]            bcIdx_d;

    // pos_mask words are the only reset state: an all-zero word tells
    // software the lane holds no stamp
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    posMask_q[w][l] <= '0;
                end
            end
        end else begin
            if (clr_en_i) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (clr_lanes_i[l]) begin
                        posMask_q[clr_wid_i][l] <= '0;
                    end
                end
            end
            if (wr_en_i) begin
                posMask_q[wr_wid_i][wr_lane_i] <= wr_data_i.pos_mask;
            end
        end
    end

    // bcoords are only meaningful alongside a non-zero pos_mask, so they
    // are left unreset
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            bcoords_q[wr_wid_i][wr_lane_i] <= wr_data_i.bcoords;
        end
    end

    // CSR index 1..12 maps linearly onto bcoords[i/4][i%4]
    always_comb begin
        bcIdx_d = rd_idx_i - 4'(RASTER_CSR_BCOORD0);
    end

    // Registered read port; reads see the storage before any same-cycle
    // write, and the data holds until the next strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            rdData_q <= '0;
        end else if (rd_en_i) begin
            if (rd_idx_i == 4'(RASTER_CSR_POS_MASK)) begin
                rdData_q <= posMask_q[rd_wid_i][rd_lane_i];
            end else if (rd_idx_i < 4'(RASTER_CSR_COUNT)) begin
                rdData_q <= bcoords_q[rd_wid_i][rd_lane_i][bcIdx_d[3:2]][bcIdx_d[1:0]];
            end else begin
                rdData_q <= '0;
            end
        end
    end

    assign rd_data_o = rdData_q;

endmodule

// File: rtl/raster_stamp_fetch.sv
// raster_stamp_fetch
// Hands rasterizer stamps to warps executing the raster-fetch instruction,
// one stamp per active lane, stores per-lane CSR state and returns a
// per-lane result word (valid bit + primitive id, or 0 when exhausted).
//   stamp_*   : stamp stream from the raster unit (valid/ready + done level)
//   req_*     : fetch request from a warp (warp id + active thread mask)
//   rsp_*     : per-lane result words back to the warp
//   csr_rd_*  : CSR read port for the core's CSR unit
module raster_stamp_fetch
    import raster_stamp_fetch_pkg::*;
#(
    parameter  int NUM_WARPS = 4,
    parameter  int NUM_LANES = 4,
    localparam int WB = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int LB = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stamp_valid,
    input  raster_stamp_t           stamp_data,
    input  logic                    stamp_done,
    output logic                    stamp_ready,
    input  logic                    req_valid,
    input  logic [WB-1:0]           req_wid,
    input  logic [NUM_LANES-1:0]    req_tmask,
    output logic                    req_ready,
    output logic                    rsp_valid,
    output logic [WB-1:0]           rsp_wid,
    output logic [NUM_LANES*32-1:0] rsp_data,
    input  logic                    rsp_ready,
    input  logic                    csr_rd_valid,
    input  logic [WB-1:0]           csr_rd_wid,
    input  logic [LB-1:0]           csr_rd_lane,
    input  logic [3:0]              csr_rd_idx,
    output logic [31:0]             csr_rd_data
);

    if (!POS_MASK_FITS) begin : gPosMaskCheck
        $error("pos_mask packing does not fit in 32 bits");
    end

    fetchState_e                 state_q;
    logic [WB-1:0]               wid_q;
    logic [NUM_LANES-1:0]        pending_q;
    logic [NUM_LANES-1:0][31:0]  result_q;
    logic                        stampReady_q;
    logic                        reqReady_q;
    logic                        rspValid_q;

    logic [LB-1:0]               curLane_d;
    logic [NUM_LANES-1:0]        pendingNext_d;
    logic [31:0]                 resultWord_d;
    logic                        stampFire_d;
    logic                        reqFire_d;
    logic                        rspFire_d;
    logic                        drain_d;
    raster_csrs_t                wrEntry_d;

    // The lane being served is always the lowest lane still waiting
    // for a stamp, which walks the active lanes in ascending order
    always_comb begin
        curLane_d = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                curLane_d = LB'(i);
            end
        end
    end

    // Handshakes, the next pending set and the data written on a stamp.
    // A stamp offered together with done still wins; draining only
    // happens when no stamp is on offer.
    always_comb begin
        stampFire_d        = stamp_valid && stampReady_q;
        reqFire_d          = req_valid && reqReady_q;
        rspFire_d          = rspValid_q && rsp_ready;
        drain_d            = stampReady_q && stamp_done && !stamp_valid;
        pendingNext_d      = pending_q & ~(NUM_LANES'(1) << curLane_d);
        resultWord_d       = '0;
        resultWord_d[RSP_VALID_BIT]  = 1'b1;
        resultWord_d[PID_BITS-1:0]   = stamp_data.pid;
        wrEntry_d.pos_mask = packPosMask(stamp_data);
        wrEntry_d.bcoords  = stamp_data.bcoords;
    end

    // Fetch controller: accept one request, collect one stamp per active
    // lane (or drain on done), then hold the response until consumed.
    // All handshake outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH_IDLE;
            wid_q        <= '0;
            pending_q    <= '0;
            result_q     <= '0;
            stampReady_q <= 1'b0;
            reqReady_q   <= 1'b0;
            rspValid_q   <= 1'b0;
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    reqReady_q <= 1'b1;
                    if (reqFire_d) begin
                        wid_q      <= req_wid;
                        pending_q  <= req_tmask;
                        result_q   <= '0;
                        reqReady_q <= 1'b0;
                        if (req_tmask == '0) begin
                            state_q    <= FETCH_RESPOND;
                            rspValid_q <= 1'b1;
                        end else begin
                            state_q      <= FETCH_COLLECT;
                            stampReady_q <= 1'b1;
                        end
                    end
                end
                FETCH_COLLECT: begin
                    if (stampFire_d) begin
                        result_q[curLane_d] <= resultWord_d;
                        pending_q           <= pendingNext_d;
                        if (pendingNext_d == '0) begin
                            state_q      <= FETCH_RESPOND;
                            stampReady_q <= 1'b0;
                            rspValid_q   <= 1'b1;
                        end
                    end else if (drain_d) begin
                        pending_q    <= '0;
                        state_q      <= FETCH_RESPOND;
                        stampReady_q <= 1'b0;
                        rspValid_q   <= 1'b1;
                    end
                end
                FETCH_RESPOND: begin
                    if (rspFire_d) begin
                        state_q    <= FETCH_IDLE;
                        rspValid_q <= 1'b0;
                        reqReady_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= FETCH_IDLE;
                    stampReady_q <= 1'b0;
                    reqReady_q   <= 1'b0;
                    rspValid_q   <= 1'b0;
                end
            endcase
        end
    end

    raster_csr_file #(
        .NUM_WARPS (NUM_WARPS),
        .NUM_LANES (NUM_LANES),
        .WB        (WB),
        .LB        (LB)
    ) csrFile (
        .clk         (clk),
        .reset       (reset),
        .wr_en_i     (stampFire_d),
        .wr_wid_i    (wid_q),
        .wr_lane_i   (curLane_d),
        .wr_data_i   (wrEntry_d),
        .clr_en_i    (drain_d),
        .clr_wid_i   (wid_q),
        .clr_lanes_i (pending_q),
        .rd_en_i     (csr_rd_valid),
        .rd_wid_i    (csr_rd_wid),
        .rd_lane_i   (csr_rd_lane),
        .rd_idx_i    (csr_rd_idx),
        .rd_data_o   (csr_rd_data)
    );

    assign stamp_ready = stampReady_q;
    assign req_ready   = reqReady_q;
    assign rsp_valid   = rspValid_q;
    assign rsp_wid     = wid_q;
    assign rsp_data    = result_q;

endmodule

// File: tb/tb_raster_stamp_fetch.sv
// tb_raster_stamp_fetch
// Drives requests and stamps into raster_stamp_fetch and compares the
// responses and CSR contents against a lane-level model of the stream.
module tb_raster_stamp_fetch;
    import raster_stamp_fetch_pkg::*;

    localparam int NW = 4;
    localparam int NL = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           stamp_valid;
    raster_stamp_t  stamp_data;
    logic           stamp_done;
    logic           stamp_ready;
    logic           req_valid;
    logic [1:0]     req_wid;
    logic [NL-1:0]  req_tmask;
    logic           req_ready;
    logic           rsp_valid;
    logic [1:0]     rsp_wid;
    logic [NL*32-1:0] rsp_data;
    logic           rsp_ready;
    logic           csr_rd_valid;
    logic [1:0]     csr_rd_wid;
    logic [1:0]     csr_rd_lane;
    logic [3:0]     csr_rd_idx;
    logic [31:0]    csr_rd_data;

    int checks = 0;
    int errors = 0;

    // Model of the CSR file contents
    logic [31:0] mPos [NW][NL];
    logic [31:0] mBc  [NW][NL][12];
    bit          mBcKnown [NW][NL];

    raster_stamp_fetch #(.NUM_WARPS(NW), .NUM_LANES(NL)) dut (
        .clk          (clk),
        .reset        (reset),
        .stamp_valid  (stamp_valid),
        .stamp_data   (stamp_data),
        .stamp_done   (stamp_done),
        .stamp_ready  (stamp_ready),
        .req_valid    (req_valid),
        .req_wid      (req_wid),
        .req_tmask    (req_tmask),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_wid      (rsp_wid),
        .rsp_data     (rsp_data),
        .rsp_ready    (rsp_ready),
        .csr_rd_valid (csr_rd_valid),
        .csr_rd_wid   (csr_rd_wid),
        .csr_rd_lane  (csr_rd_lane),
        .csr_rd_idx   (csr_rd_idx),
        .csr_rd_data  (csr_rd_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected pos_mask word: mask | pos_x << 4 | pos_y << (4 + DIM - 1)
    function automatic logic [31:0] modelPos(input raster_stamp_t s);
        return 32'(s.mask) | (32'(s.pos_x) << 4) | (32'(s.pos_y) << (4 + VX_RASTER_DIM_BITS - 1));
    endfunction

    task automatic makeStamp(input int pidBase, input int i, output raster_stamp_t s, output logic [31:0] w [12]);
        s = '0;
        if (pidBase >= 0) begin
            s.pid   = 16'(pidBase + i);
            s.pos_x = 11'(i + 1);
            s.pos_y = 11'(i + 2);
            s.mask  = 4'(15 - i);
        end else begin
            s.pid   = 16'($urandom);
            s.pos_x = 11'($urandom);
            s.pos_y = 11'($urandom);
            s.mask  = 4'($urandom);
        end
        for (int j = 0; j < 12; j++) begin
            w[j] = (pidBase >= 0) ? 32'((pidBase + i) * 256 + j + 1) : $urandom;
            s.bcoords[j / 4][j % 4] = w[j];
        end
    endtask

    task automatic modelWrite(input int wid, input int lane, input raster_stamp_t s, input logic [31:0] w [12]);
        mPos[wid][lane] = modelPos(s);
        for (int j = 0; j < 12; j++) mBc[wid][lane][j] = w[j];
        mBcKnown[wid][lane] = 1'b1;
    endtask

    task automatic csrRead(input int w, input int l, input int idx, output logic [31:0] d);
        csr_rd_valid = 1'b1;
        csr_rd_wid   = 2'(w);
        csr_rd_lane  = 2'(l);
        csr_rd_idx   = 4'(idx);
        tick();
        csr_rd_valid = 1'b0;
        d = csr_rd_data;
    endtask

    task automatic checkCsrEntry(input int w, input int l);
        logic [31:0] d;
        int j;
        csrRead(w, l, 0, d);
        checkOutput($sformatf("csr_pos w%0d l%0d", w, l), d, mPos[w][l]);
        if (mBcKnown[w][l]) begin
            j = $urandom_range(0, 11);
            csrRead(w, l, j + 1, d);
            checkOutput($sformatf("csr_bc%0d w%0d l%0d", j, w, l), d, mBc[w][l][j]);
        end
        csrRead(w, l, $urandom_range(13, 15), d);
        checkOutput("csr_unused_idx", d, 0);
    endtask

    task automatic waitReqReady();
        int cyc = 0;
        while (!req_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        checkOutput("req_ready_wait", req_ready, 1);
    endtask

    task automatic checkRsp(input string tag, input int wid, input logic [31:0] expRes [NL]);
        checkOutput({tag, "_valid"}, rsp_valid, 1);
        checkOutput({tag, "_wid"}, rsp_wid, wid);
        for (int l = 0; l < NL; l++) begin
            checkOutput($sformatf("%s_lane%0d", tag, l), rsp_data[l*32 +: 32], expRes[l]);
        end
    endtask

    // One complete fetch: request, stamp stream, response, CSR readback
    task automatic applyStimulus(input int wid, input logic [NL-1:0] tmask, input int nStamps,
                                 input bit gaps, input int rspDelay, input bit doneWithLast,
                                 input int pidBase, input bit checkLat);
        raster_stamp_t st [4];
        logic [31:0]   words [4][12];
        logic [31:0]   w1 [12];
        logic [31:0]   expRes [NL];
        int            lanes [$];
        int            popped = 0;
        int            cyc = 0;
        bit            fire;
        for (int l = 0; l < NL; l++) begin
            expRes[l] = 0;
            if (tmask[l]) lanes.push_back(l);
        end
        for (int i = 0; i < nStamps; i++) begin
            makeStamp(pidBase, i, st[i], w1);
            for (int j = 0; j < 12; j++) words[i][j] = w1[j];
        end
        waitReqReady();
        req_valid = 1'b1;
        req_wid   = 2'(wid);
        req_tmask = tmask;
        tick();
        req_valid = 1'b0;
        while (!rsp_valid && cyc < 200) begin
            if (popped < nStamps) begin
                stamp_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                stamp_data  = st[popped];
                stamp_done  = doneWithLast && (popped == nStamps - 1) && stamp_valid;
            end else begin
                stamp_valid = 1'b0;
                stamp_done  = 1'b1;
            end
            fire = stamp_valid && stamp_ready;
            tick();
            cyc++;
            if (fire && popped < lanes.size()) begin
                for (int j = 0; j < 12; j++) w1[j] = words[popped][j];
                modelWrite(wid, lanes[popped], st[popped], w1);
                expRes[lanes[popped]] = 32'h8000_0000 | 32'(st[popped].pid);
                popped++;
            end
        end
        stamp_valid = 1'b0;
        stamp_done  = 1'b0;
        for (int i = popped; i < lanes.size(); i++) mPos[wid][lanes[i]] = 0;
        checkOutput("rsp_timeout", rsp_valid, 1);
        if (checkLat) checkOutput("latency", cyc + 1, lanes.size() + 1);
        checkRsp("rsp", wid, expRes);
        checkOutput("stamp_ready_in_rsp", stamp_ready, 0);
        for (int d = 0; d < rspDelay; d++) begin
            tick();
            checkRsp("hold", wid, expRes);
            checkOutput("hold_stamp_ready", stamp_ready, 0);
            checkOutput("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("rsp_dropped", rsp_valid, 0);
        checkOutput("req_ready_after_rsp", req_ready, 1);
        for (int i = 0; i < lanes.size(); i++) checkCsrEntry(wid, lanes[i]);
    endtask

    initial begin
        raster_stamp_t s;
        logic [31:0]   w [12];
        logic [31:0]   d;
        logic [NL-1:0] tm;
        int            cnt;

        reset = 1'b1;
        stamp_valid = 1'b0; stamp_data = '0; stamp_done = 1'b0;
        req_valid = 1'b0; req_wid = '0; req_tmask = '0;
        rsp_ready = 1'b0;
        csr_rd_valid = 1'b0; csr_rd_wid = '0; csr_rd_lane = '0; csr_rd_idx = '0;
        for (int a = 0; a < NW; a++) begin
            for (int b = 0; b < NL; b++) begin
                mPos[a][b] = 0;
                mBcKnown[a][b] = 1'b0;
            end
        end
        repeat (3) tick();
        checkOutput("reset_stamp_ready", stamp_ready, 0);
        checkOutput("reset_req_ready", req_ready, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_wid", rsp_wid, 0);
        checkOutput("reset_rsp_data_lo", rsp_data[63:0], 0);
        checkOutput("reset_rsp_data_hi", rsp_data[127:64], 0);
        checkOutput("reset_csr_rd_data", csr_rd_data, 0);
        reset = 1'b0;
        tick();
        checkCsrEntry(2, 3);

        $display("[TB] directed: three stamps into tmask 1011");
        applyStimulus(2, 4'b1011, 3, 1'b0, 0, 1'b0, 5, 1'b1);

        $display("[TB] directed: exhausted after one stamp");
        applyStimulus(0, 4'b1111, 4, 1'b0, 0, 1'b0, -1, 1'b1);
        applyStimulus(0, 4'b1111, 1, 1'b0, 0, 1'b0, 9, 1'b0);

        $display("[TB] directed: empty thread mask");
        applyStimulus(1, 4'b0000, 0, 1'b0, 0, 1'b0, -1, 1'b1);

        $display("[TB] directed: response backpressure");
        applyStimulus(3, 4'b0110, 2, 1'b0, 5, 1'b0, -1, 1'b1);

        $display("[TB] directed: stamp with done, same-cycle CSR read");
        applyStimulus(1, 4'b0001, 1, 1'b0, 0, 1'b0, -1, 1'b0);
        waitReqReady();
        req_valid = 1'b1; req_wid = 2'd1; req_tmask = 4'b0001;
        tick();
        req_valid = 1'b0;
        makeStamp(-1, 0, s, w);
        stamp_valid = 1'b1; stamp_done = 1'b1; stamp_data = s;
        csr_rd_valid = 1'b1; csr_rd_wid = 2'd1; csr_rd_lane = 2'd0; csr_rd_idx = 4'd0;
        tick();
        stamp_valid = 1'b0; stamp_done = 1'b0; csr_rd_valid = 1'b0;
        checkOutput("same_cycle_old", csr_rd_data, mPos[1][0]);
        modelWrite(1, 0, s, w);
        checkOutput("done_stamp_rsp_valid", rsp_valid, 1);
        checkOutput("done_stamp_lane0", rsp_data[31:0], 32'h8000_0000 | 32'(s.pid));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkCsrEntry(1, 0);

        $display("[TB] directed: reset mid-collect");
        waitReqReady();
        req_valid = 1'b1; req_wid = 2'd3; req_tmask = 4'b1111;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            makeStamp(-1, i, s, w);
            stamp_valid = 1'b1; stamp_data = s;
            tick();
            mBcKnown[3][i] = 1'b0;
        end
        stamp_valid = 1'b0;
        reset = 1'b1;
        tick();
        checkOutput("midreset_rsp_valid", rsp_valid, 0);
        checkOutput("midreset_stamp_ready", stamp_ready, 0);
        checkOutput("midreset_req_ready", req_ready, 0);
        reset = 1'b0;
        for (int a = 0; a < NW; a++) begin
            for (int b = 0; b < NL; b++) mPos[a][b] = 0;
        end
        tick();
        checkOutput("postreset_rsp_valid", rsp_valid, 0);
        checkOutput("postreset_req_ready", req_ready, 1);
        csrRead(3, 0, 0, d);
        checkOutput("postreset_pos_w3l0", d, 0);
        csrRead(2, 3, 0, d);
        checkOutput("postreset_pos_w2l3", d, 0);
        applyStimulus(3, 4'b1111, 4, 1'b0, 0, 1'b0, -1, 1'b1);

        $display("[TB] randomized requests");
        for (int r = 0; r < 25; r++) begin
            tm  = 4'($urandom);
            cnt = $countones(tm);
            applyStimulus($urandom_range(0, 3), tm, $urandom_range(0, cnt), 1'b1,
                          $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/raster_stamp_fetch.md
Name: raster_stamp_fetch

Overview:
Consumer end of the rasterizer stamp stream: pops raster_stamp_t stamps and hands them to warps executing the raster-fetch instruction, one stamp per active lane. Stores each lane's per-stamp state (pos_mask plus 12 bcoords words, the raster_csrs_t layout) in a per-warp/per-lane CSR file, which the core's CSR unit reads. Returns a per-lane response word carrying the primitive id, or an "exhausted" marker once the rasterizer signals done. Sits between the raster unit output and the core's SFU/CSR path.

Parameters:
NUM_WARPS, 4, warps served; wid width WB = clog2(NUM_WARPS), min 1
NUM_LANES, 4, threads per warp; lane index width LB = clog2(NUM_LANES), min 1

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
stamp_valid  in  1  stamp available
stamp_data  in  $bits(raster_stamp_t)  incoming stamp
stamp_done  in  1  rasterizer has no further stamps (level)
stamp_ready  out  1  stamp accepted when valid&ready
req_valid  in  1  fetch request
req_wid  in  WB  requesting warp
req_tmask  in  NUM_LANES  active lanes
req_ready  out  1  request accepted
rsp_valid  out  1  response valid
rsp_wid  out  WB  warp of response
rsp_data  out  NUM_LANES*32  per-lane result word
rsp_ready  in  1  response consumed
csr_rd_valid  in  1  CSR read strobe
csr_rd_wid  in  WB  warp
csr_rd_lane  in  LB  lane
csr_rd_idx  in  4  0 = pos_mask; 1..12 = bcoords[(idx-1)/4][(idx-1)%4]; 13..15 read 0
csr_rd_data  out  32  read data, registered

Behaviour:
- One clock, synchronous active-high reset. Reset values: stamp_ready=0, req_ready=0 during reset then 1, rsp_valid=0, rsp_wid=0, rsp_data=0, csr_rd_data=0, FSM=IDLE, all pos_mask words=0. bcoords storage is not reset.
- pos_mask packing: bits[3:0]=mask, [4 +: DIM-1]=pos_x, next DIM-1 bits=pos_y, remaining upper bits 0. DIM = VX_RASTER_DIM_BITS; the package asserts 2*(DIM-1)+4 <= 32.
- Result word, lane with stamp: bit31=1, low PID_BITS = pid, other bits 0. Lane without stamp (inactive or exhausted): 0.
- FSM:
  - IDLE: req_ready=1. On req fire, latch wid and tmask, clear per-lane result regs, set lane ptr to the lowest set tmask bit. tmask==0 -> RESPOND next cycle; otherwise -> COLLECT.
  - COLLECT: stamp_ready=1, req_ready=0.
    - On stamp fire: write the pos_mask word and 12 bcoords words to [wid][ptr], set result[ptr]. Advance ptr to the next higher active lane. If none remains -> RESPOND.
    - If stamp_done=1 and stamp_valid=0: clear pos_mask of all remaining active lanes including ptr, leave their results 0 -> RESPOND.
    - If stamp_valid and stamp_done are both high, the stamp wins.
  - RESPOND: rsp_valid=1 with stable rsp_wid/rsp_data until rsp_ready; on fire -> IDLE. req_ready=0 and stamp_ready=0 throughout.
- Throughput: at most 1 stamp/cycle. Minimum latency req fire -> rsp_valid is k+1 cycles for k active lanes with stamps always valid.
- CSR read: data appears the cycle after csr_rd_valid and holds until the next strobe. A read to an entry written in the same cycle returns the old value. Reads are served in every FSM state.
- Reset mid-COLLECT or mid-RESPOND: return to IDLE, drop the partial response, clear pos_mask words. Stamps already popped are lost; upstream resets with the same reset.
- Response order is strictly request order (single outstanding request).

Decomposition:
- Shared package: pos_mask field offsets/widths, the result-word valid bit index (31), CSR index constants (RASTER_CSR_POS_MASK=0, RASTER_CSR_BCOORD0=1, count 13), and the width assertion. Reuse raster_stamp_t and raster_csrs_t.
- One natural sub-module: raster_csr_file. It holds NUM_WARPS*NUM_LANES*raster_csrs_t with one full-entry write port, one registered 32-bit indexed read port, and pos_mask clear on reset or on a per-entry clear strobe.

Test Plan:
- Reset, then req wid=2 tmask=4'b1011; push stamps pid=5,6,7 with bcoords filled by index -> results lanes 0,1,3 = 0x80000005, 0x80000006, 0x80000007; lane 2 = 0; latency 4 cycles; csr_rd wid=2 lane=3 idx=0 returns the packed pos_mask.
- req tmask=4'b1111; one stamp pid=9, then stamp_done=1 -> lane0 = 0x80000009, lanes 1-3 = 0; their pos_mask reads 0.
- req tmask=0 -> rsp_valid the next cycle, all-zero data, no stamp consumed (stamp_ready stays 0).
- Hold rsp_ready=0 for 5 cycles -> rsp stable, stamp_ready=0, req_ready=0; second request waits and is accepted the cycle after the response fires.
- stamp_valid and stamp_done high together on the last lane -> the stamp is taken and the lane result is valid; CSR read of an entry in the same cycle it is written returns the old value, and the new value on the next read.
- Assert reset after 2 of 4 stamps collected -> rsp_valid stays 0, FSM returns to IDLE, and a subsequent request completes normally.
